// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: fetches 64-byte lines from the cache over the
// request/response bus into a line buffer and streams 32-bit
// instructions with their PCs to decode over a valid/ready handshake.
// Ports: clk, reset (sync, active-high), entry (start PC);
//   bus_req* (line request + tag), bus_resp* (8 beats + tag, ack);
//   redirect_valid/redirect_pc (flush + restart);
//   inst_valid/inst_ready/inst/inst_pc (decode side).
// Option: define FETCH_BYPASS_EN to hand out words while the line
//   is still arriving, as soon as the beat holding pc is in.
module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] entry,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      redirect_valid,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [BUS_DATA_WIDTH-1:0] inst_pc
);

  localparam int LW = BUS_DATA_WIDTH * LINE_BEATS;
  localparam int SW = BUS_TAG_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic [SW-1:0]             seq_q, seq_d;
  logic [2:0]                beat_q, beat_d;
  logic                      discard_q, discard_d;
  logic                      taken_q, taken_d;
  logic [LW-1:0]             line_q, line_d;

  logic [BUS_TAG_WIDTH-1:0]  out_tag;
  logic [BUS_DATA_WIDTH-1:0] redir_pc;
  logic                      capture;
  logic                      last_beat;
  logic                      hs;
  logic                      word15;
  logic                      refetch;

  // seq already advanced when the request was accepted
  assign out_tag   = {1'b1, seq_q - SW'(1)};
  assign redir_pc  = redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign capture   = (state_q == RECV) && bus_respcyc
                   && !taken_q && (bus_resptag == out_tag);
  assign last_beat = capture && (beat_q == 3'd7);
  assign hs        = inst_valid && inst_ready && !redirect_valid;
  assign word15    = (pc_q[5:2] == 4'hf);

`ifdef FETCH_BYPASS_EN
  // beats land in order, so beat_q counts how many are present
  assign inst_valid = (state_q == DRAIN)
                    || ((state_q == RECV) && !discard_q
                        && (pc_q[5:3] < beat_q));
`else
  assign inst_valid = (state_q == DRAIN);
`endif

  assign inst    = inst_valid ? line_q[{pc_q[5:2], 5'b0} +: 32] : '0;
  assign inst_pc = inst_valid ? pc_q : '0;

  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? {pc_q[BUS_DATA_WIDTH-1:6], 6'b0} : '0;
  assign bus_reqtag  = bus_reqcyc ? {1'b1, seq_q} : '0;
  assign bus_respack = taken_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    seq_d     = seq_q;
    beat_d    = beat_q;
    discard_d = discard_q;
    taken_d   = taken_q;
    line_d    = line_q;
    refetch   = 1'b0;

    // one capture per beat: taken holds until respcyc drops
    if (bus_respcyc && !taken_q) begin
      taken_d = 1'b1;
    end else if (!bus_respcyc) begin
      taken_d = 1'b0;
    end

    if (capture) begin
      line_d[{beat_q, 6'b0} +: BUS_DATA_WIDTH] = bus_resp;
      beat_d = beat_q + 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        pc_d    = entry & ~BUS_DATA_WIDTH'(3);
        state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        // a redirect in the ack cycle still owns the burst
        if (bus_reqack) begin
          state_d   = RECV;
          seq_d     = seq_q + SW'(1);
          beat_d    = 3'd0;
          discard_d = redirect_valid;
        end
      end
      RECV: begin
        refetch = discard_q;
        if (redirect_valid) begin
          pc_d    = redir_pc;
          refetch = 1'b1;
        end else if (hs) begin
          pc_d = pc_q + BUS_DATA_WIDTH'(4);
          // left the line early; wait out the burst
          if (word15) refetch = 1'b1;
        end
        discard_d = refetch;
        if (last_beat) begin
          state_d   = refetch ? REQ : DRAIN;
          discard_d = 1'b0;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (hs) begin
          pc_d = pc_q + BUS_DATA_WIDTH'(4);
          if (word15) state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      seq_q     <= '0;
      beat_q    <= '0;
      discard_q <= 1'b0;
      taken_q   <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      seq_q     <= seq_d;
      beat_q    <= beat_d;
      discard_q <= discard_d;
      taken_q   <= taken_d;
      line_q    <= line_d;
    end
  end

endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Instruction-fetch front end that sits directly upstream of the set-associative cache on its processor-side bus. It issues 64-byte line read requests over the request/response bus, captures the eight 64-bit response beats into a line buffer, and streams 32-bit instructions with their PCs to decode under a valid/ready handshake. Control-flow redirects flush the buffer and restart fetch.

## Interface
- BUS_DATA_WIDTH, 64, bus address/data width
- BUS_TAG_WIDTH, 13, bus tag width; bit 12 = 1 marks a read
- LINE_BEATS, 8, response beats per line (fixed at 8 for 64-byte lines)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- entry  in  64  PC loaded after reset
- bus_reqcyc  out  1  request valid to cache
- bus_reqack  in  1  cache accepted request
- bus_req  out  64  line-aligned request address
- bus_reqtag  out  13  request tag, {1'b1, seq[11:0]}
- bus_respcyc  in  1  cache presents a response beat
- bus_respack  out  1  beat accepted
- bus_resp  in  64  response beat data
- bus_resptag  in  13  response tag
- redirect_valid  in  1  redirect fetch to redirect_pc
- redirect_pc  in  64  new PC; bits [1:0] ignored (forced 0)
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  64  PC of inst

## Operation
- States: IDLE, REQ, RECV, DRAIN. Reset forces IDLE.
- IDLE: pc <= {entry[63:2],2'b0}; next REQ. Lasts exactly one cycle.
- REQ: bus_reqcyc=1, bus_req={pc[63:6],6'b0}, bus_reqtag={1,seq}; held stable until bus_reqack sampled 1, then RECV, seq <= seq+1, beat <= 0.
- RECV: beat k captured into line[64k+:64] on a cycle with bus_respcyc=1 and taken=0, only when bus_resptag equals the outstanding tag; taken <= 1. bus_respack = taken (registered); taken clears the cycle after bus_respcyc is sampled 0. Mismatched-tag beats are acked the same way but neither stored nor counted. After beat 7 is captured: DRAIN, or REQ if discard set.
- DRAIN: inst = line[32*pc[5:2] +: 32], inst_pc = pc, inst_valid=1. On valid&ready: pc <= pc+4; if pc[5:2]==15, next REQ (sequential next line).
- Redirect, any state except IDLE: pc <= redirect_pc. In DRAIN or REQ-before-ack: go REQ immediately, the old request is dropped. In RECV, or in REQ in the ack cycle: set discard, finish all 8 beats, then REQ. A bus transaction is never abandoned mid-burst.
- Redirect and inst handshake in the same cycle: redirect wins, and the handshake is not counted.
- Address arithmetic is 64-bit modulo and wraps silently. seq is 12 bits and wraps to 0.

## Timing
- Reset values: bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0, inst_valid=0, inst=0, inst_pc=0, seq=0, discard=0, taken=0.
- Reset asserted mid-operation: IDLE the next cycle, all outputs as above, and any in-flight burst is abandoned.
- bus_reqcyc first rises 2 cycles after reset deasserts (IDLE, then REQ).
- Redirect in DRAIN at cycle t: inst_valid=0 and bus_reqcyc=1 from t+1.
- Minimum time per beat: 2 cycles (capture, then ack). The ack stays high while bus_respcyc stays high.
- Best-case throughput in DRAIN: 1 instruction/cycle. A line supplies 16 instructions, or fewer when the entry PC is mid-line.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.

## Configuration
- FETCH_BYPASS_EN defined: in RECV, inst_valid=1 once the beat holding pc (beat pc[5:3]) has been captured and discard=0. Handshakes advance pc during RECV. A handshake at word 15 during RECV moves to REQ only after beat 7 is captured.
- Undefined: inst_valid=1 only in DRAIN, i.e. after all 8 beats have arrived.

## Test plan
- Reset, entry=0x1000: REQ with bus_req=0x1000, tag=0x1000; beats 0x..0_1..0x..0_8 and ready=1 give 16 instructions, PCs 0x1000–0x103C, then request 0x1040, tag 0x1001.
- entry=0x1038: first inst_pc=0x1038, word from beat 7 [31:0]; the second instruction is at 0x103C, after which the block requests 0x1040.
- Redirect to 0x2004 during beat 3 of RECV: all 8 beats acked, no inst_valid, then request 0x2000; first inst_pc=0x2004.
- Cache holds bus_respcyc high for 3 cycles per beat: exactly one capture per beat, bus_respack high from the 2nd cycle until bus_respcyc falls.
- Beat with a wrong resptag: acked but not stored; the line completes on 8 correct beats.
- FETCH_BYPASS_EN: inst at 0x1000 becomes valid the cycle after beat 0 is captured; without the macro it becomes valid only after beat 7.
